reg_writeback_file: RTL and testbench

// Destination end of the register move/ALU result path: accepts result words (e.g. MOV/ALU outputs)

---
 rtl/reg_writeback_file.sv | 95 +++++++++
 tb/tb_reg_writeback_file.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_file.sv
// Writeback register file: 2-entry in-order write queue committing one entry per cycle,
// with two 1-cycle-latency read ports that forward from queued and in-flight writes.
module reg_writeback_file #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned ZERO_REG  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 commit_stall,
  input  logic [ADDR_W-1:0]    rd1_addr,
  output logic [WORD_SIZE-1:0] rd1_data,
  input  logic [ADDR_W-1:0]    rd2_addr,
  output logic [WORD_SIZE-1:0] rd2_data,
  output logic [1:0]           pending
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;
  localparam int unsigned DEPTH    = 2;

  logic [WORD_SIZE-1:0] r_regs   [NUM_REGS];
  logic [ADDR_W-1:0]    r_q_addr [DEPTH];
  logic [WORD_SIZE-1:0] r_q_data [DEPTH];
  logic                 r_head;
  logic [1:0]           r_count;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_tail;
  logic                 w_head_is_r0;
  logic [ADDR_W-1:0]    w_rd_addr [2];
  logic [WORD_SIZE-1:0] w_fwd     [2];

  assign wr_ready     = (r_count != 2'd2);
  assign pending      = r_count;
  assign w_push       = wr_valid & wr_ready;
  assign w_pop        = (r_count != 2'd0) & ~commit_stall;
  assign w_tail       = r_head ^ (r_count != 2'd0);
  assign w_head_is_r0 = (ZERO_REG != 0) && (r_q_addr[r_head] == '0);
  assign w_rd_addr[0] = rd1_addr;
  assign w_rd_addr[1] = rd2_addr;

  // Forwarding: committed file, then queued entries oldest->youngest, then this edge's push.
  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      w_fwd[p] = r_regs[w_rd_addr[p]];
      for (int i = 0; i < DEPTH; i++) begin
        if ((2'(i) < r_count) && (r_q_addr[r_head ^ 1'(i)] == w_rd_addr[p])) begin
          w_fwd[p] = r_q_data[r_head ^ 1'(i)];
        end
      end
      if (w_push && (wr_addr == w_rd_addr[p])) begin
        w_fwd[p] = wr_data;
      end
      if ((ZERO_REG != 0) && (w_rd_addr[p] == '0)) begin
        w_fwd[p] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        r_q_addr[i] <= '0;
        r_q_data[i] <= '0;
      end
      r_head   <= 1'b0;
      r_count  <= 2'd0;
      rd1_data <= '0;
      rd2_data <= '0;
    end else begin
      if (w_pop) begin
        if (!w_head_is_r0) begin
          r_regs[r_q_addr[r_head]] <= r_q_data[r_head];
        end
        r_head <= ~r_head;
      end
      if (w_push) begin
        r_q_addr[w_tail] <= wr_addr;
        r_q_data[w_tail] <= wr_data;
      end
      r_count  <= r_count + 2'(w_push) - 2'(w_pop);
      rd1_data <= w_fwd[0];
      rd2_data <= w_fwd[1];
    end
  end

endmodule

// File: tb/tb_reg_writeback_file.sv
// Self-checking bench for reg_writeback_file: a behavioural model predicts read data,
// wr_ready and pending each cycle; expected read data is queued and compared after the edge.
module tb_reg_writeback_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        commit_stall;
  logic [3:0]  rd1_addr;
  logic [31:0] rd1_data;
  logic [3:0]  rd2_addr;
  logic [31:0] rd2_data;
  logic [1:0]  pending;

  reg_writeback_file #(.WORD_SIZE(32), .ADDR_W(4), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .commit_stall(commit_stall),
    .rd1_addr(rd1_addr), .rd1_data(rd1_data), .rd2_addr(rd2_addr),
    .rd2_data(rd2_data), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
  } ent_t;

  logic [31:0] m_regs [16];
  ent_t        mq[$];
  logic [31:0] exp1_q[$];
  logic [31:0] exp2_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Value of register a as seen by all writes accepted up to and including this edge.
  function automatic logic [31:0] mread(input logic [3:0] a, input bit push);
    logic [31:0] v;
    if (a == 4'd0) return 32'h0;
    v = m_regs[a];
    foreach (mq[i]) if (mq[i].a == a) v = mq[i].d;
    if (push && wr_addr == a) v = wr_data;
    return v;
  endfunction

  // One clock: predict, advance model, clock DUT, compare read ports.
  task automatic cycle();
    bit push, pop;
    ent_t e;
    if (rst) begin
      exp1_q.push_back(32'h0);
      exp2_q.push_back(32'h0);
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      mq.delete();
    end else begin
      check("wr_ready", 32'(wr_ready), 32'(mq.size() != 2));
      check("pending", 32'(pending), 32'(mq.size()));
      push = wr_valid && (mq.size() != 2);
      pop  = (mq.size() != 0) && !commit_stall;
      exp1_q.push_back(mread(rd1_addr, push));
      exp2_q.push_back(mread(rd2_addr, push));
      if (pop) begin
        e = mq.pop_front();
        if (e.a != 4'd0) m_regs[e.a] = e.d;
      end
      if (push) mq.push_back('{a: wr_addr, d: wr_data});
    end
    @(posedge clk);
    #1;
    if (exp1_q.size() != 0) check("rd1_data", rd1_data, exp1_q.pop_front());
    if (exp2_q.size() != 0) check("rd2_data", rd2_data, exp2_q.pop_front());
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    commit_stall = 1'b0; rd1_addr = '0; rd2_addr = '0;
    cycle();
    cycle();
    rst = 1'b0;

    // Reset state: every register reads zero on both ports
    for (int a = 0; a < 16; a++) begin
      rd1_addr = 4'(a);
      rd2_addr = 4'(15 - a);
      cycle();
    end
    cycle();
    check("t1_pending", 32'(pending), 32'd0);
    check("t1_ready", 32'(wr_ready), 32'd1);

    // Single write then read-back
    wr(4'd3, 32'h0000_00A5);
    cycle();
    wr_valid = 1'b0;
    check("t2_pending1", 32'(pending), 32'd1);
    rd1_addr = 4'd3;
    cycle();
    check("t2_pending0", 32'(pending), 32'd0);
    check("t2_rd1", rd1_data, 32'h0000_00A5);

    // Stall: fill queue, third write held off, younger write to r5 wins
    commit_stall = 1'b1;
    wr(4'd5, 32'h11); cycle();
    wr(4'd5, 32'h22); cycle();
    check("t3_ready_full", 32'(wr_ready), 32'd0);
    wr(4'd6, 32'h33);
    rd2_addr = 4'd5;
    cycle();
    check("t3_rd2_fwd", rd2_data, 32'h22);
    check("t3_pending_full", 32'(pending), 32'd2);
    cycle();
    commit_stall = 1'b0;
    cycle();
    check("t3_pending_pop", 32'(pending), 32'd1);
    cycle();
    wr_valid = 1'b0;
    cycle();
    check("t3_drained", 32'(pending), 32'd0);
    rd1_addr = 4'd5; rd2_addr = 4'd6;
    cycle();
    check("t3_r5", rd1_data, 32'h22);
    check("t3_r6", rd2_data, 32'h33);

    // Full queue: pending 2 -> 1 (pop only) -> 2 (push while stalled)
    commit_stall = 1'b1;
    wr(4'd9, 32'h91); cycle();
    wr(4'd10, 32'hA1); cycle();
    check("t4_p2", 32'(pending), 32'd2);
    wr(4'd11, 32'hB1);
    commit_stall = 1'b0;
    cycle();
    check("t4_p1", 32'(pending), 32'd1);
    commit_stall = 1'b1;
    cycle();
    check("t4_p2b", 32'(pending), 32'd2);
    wr_valid = 1'b0; commit_stall = 1'b0;
    cycle(); cycle(); cycle();
    rd1_addr = 4'd10; rd2_addr = 4'd11;
    cycle();
    check("t4_r10", rd1_data, 32'hA1);
    check("t4_r11", rd2_data, 32'hB1);

    // Zero register discards writes but still occupies a slot
    rd1_addr = 4'd0;
    wr(4'd0, 32'hDEAD_BEEF);
    cycle();
    wr_valid = 1'b0;
    check("t5_pending1", 32'(pending), 32'd1);
    cycle();
    check("t5_pending0", 32'(pending), 32'd0);
    check("t5_r0", rd1_data, 32'h0);

    // Reset mid-stream discards queued writes
    commit_stall = 1'b1;
    wr(4'd7, 32'h1); cycle();
    wr(4'd8, 32'h2); cycle();
    wr_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0; commit_stall = 1'b0;
    check("t6_pending", 32'(pending), 32'd0);
    rd1_addr = 4'd7; rd2_addr = 4'd8;
    cycle();
    check("t6_r7", rd1_data, 32'h0);
    check("t6_r8", rd2_data, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      wr_valid     = ($urandom_range(0, 3) != 0);
      wr_addr      = 4'($urandom_range(0, 15));
      wr_data      = $urandom;
      commit_stall = ($urandom_range(0, 3) == 0);
      rd1_addr     = ($urandom_range(0, 1) != 0) ? wr_addr : 4'($urandom_range(0, 15));
      rd2_addr     = 4'($urandom_range(0, 15));
      rst          = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0; wr_valid = 1'b0; commit_stall = 1'b0;
    cycle(); cycle(); cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
